shift_sequencer: RTL and testbench

- Control stage directly upstream of the 16-bit 4-mode shift register.
- Accepts a parallel word plus a shift command over a start/ready handshake.
- Drives the register's mode select (S), parallel load bus (I) and serial fill bit: one LOAD cycle, then exactly `amount` shift cycles, then a one-cycle done pulse.
- Lets the datapath perform multi-bit left/right shifts without per-cycle software control.

---
 rtl/shift_sequencer_if.sv | 29 ++
 rtl/shift_sequencer.sv | 110 +++++++++++
 tb/tb_shift_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/control bundle between requester, sequencer and shift register
interface shift_sequencer_if #(
    parameter int N  = 16,
    parameter int CW = 5
);
    logic [N-1:0]  data_in;
    logic          start;
    logic          ready;
    logic          dir;
    logic [CW-1:0] amount;
    logic          fill;
    logic [1:0]    S;
    logic [N-1:0]  I;
    logic          ser_in;
    logic          busy;
    logic          done;

    // requester side: issues commands, observes sequencer status and drive
    modport master (
        output data_in, start, dir, amount, fill,
        input  ready, S, I, ser_in, busy, done
    );

    // sequencer side
    modport slave (
        input  data_in, start, dir, amount, fill,
        output ready, S, I, ser_in, busy, done
    );
endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - load-then-shift control sequencer for a 4-mode shift register
module shift_sequencer #(
    parameter int N  = 16,
    parameter int CW = 5
) (
    input  logic               clk,
    input  logic               rst,
    shift_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0]    MODE_HOLD  = 2'd0;
    localparam logic [1:0]    MODE_LEFT  = 2'd1;
    localparam logic [1:0]    MODE_RIGHT = 2'd2;
    localparam logic [1:0]    MODE_LOAD  = 2'd3;
    localparam logic [CW-1:0] AMT_MAX    = CW'(N);
    localparam logic [CW-1:0] ONE        = CW'(1);

    state_t        state;
    logic [N-1:0]  word_q;
    logic          dir_q;
    logic          fill_q;
    logic [CW-1:0] amt_q;
    logic [CW-1:0] cnt;
    logic [1:0]    mode_q;
    logic          busy_q;
    logic          done_q;
    logic          idle_q;

    // Sequencer FSM: next state, latched command and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            word_q <= '0;
            dir_q  <= 1'b0;
            fill_q <= 1'b0;
            amt_q  <= '0;
            cnt    <= '0;
            mode_q <= MODE_HOLD;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            idle_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        word_q <= bus.data_in;
                        dir_q  <= bus.dir;
                        fill_q <= bus.fill;
                        amt_q  <= (bus.amount > AMT_MAX) ? AMT_MAX : bus.amount;
                        state  <= LOAD;
                        mode_q <= MODE_LOAD;
                        busy_q <= 1'b1;
                        idle_q <= 1'b0;
                    end
                end
                LOAD: begin
                    // counter is primed here so the first SHIFT cycle already sees the full amount
                    cnt <= amt_q;
                    if (amt_q != '0) begin
                        state  <= SHIFT;
                        mode_q <= dir_q ? MODE_RIGHT : MODE_LEFT;
                    end else begin
                        state  <= DONE;
                        mode_q <= MODE_HOLD;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    cnt <= cnt - ONE;
                    if (cnt == ONE) begin
                        state  <= DONE;
                        mode_q <= MODE_HOLD;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    idle_q <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    mode_q <= MODE_HOLD;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    idle_q <= 1'b1;
                end
            endcase
        end
    end

    // ready is masked while reset is held so no request can be accepted into a reset cycle
    assign bus.ready  = idle_q & ~rst;
    assign bus.S      = mode_q;
    assign bus.I      = word_q;
    assign bus.ser_in = fill_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed self-checking bench for shift_sequencer
module tb_shift_sequencer;

    localparam int N  = 16;
    localparam int CW = 5;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [N-1:0] q;

    shift_sequencer_if #(.N(N), .CW(CW)) bus ();

    shift_sequencer #(.N(N), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // downstream 4-mode shift register model
    always @(posedge clk) begin
        case (bus.S)
            2'd1:    q <= {q[N-2:0], bus.ser_in};
            2'd2:    q <= {bus.ser_in, q[N-1:1]};
            2'd3:    q <= bus.I;
            default: q <= q;
        endcase
    end

    // exclusivity of status flags, sampled away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (!(bus.busy && bus.ready) && !(bus.busy && bus.done)) else begin
                errors++;
                $error("FAIL flag_excl busy=%0d ready=%0d done=%0d required no overlap",
                       bus.busy, bus.ready, bus.done);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] d, input logic dr, input logic [CW-1:0] am,
                         input logic fl);
        bus.data_in = d;
        bus.dir     = dr;
        bus.amount  = am;
        bus.fill    = fl;
    endtask

    // issue one request and follow it to completion
    task automatic run_op(input string tag, input logic [N-1:0] d, input logic dr,
                          input logic [CW-1:0] am, input logic fl, input int a,
                          input logic [N-1:0] exp_q);
        int n;
        int shifts;
        int bad_mode;
        logic [1:0] exp_mode;
        exp_mode = dr ? 2'd2 : 2'd1;
        chk({tag, " ready_before"}, 32'(bus.ready), 32'd1);
        drive(d, dr, am, fl);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        drive(~d, ~dr, 5'd7, ~fl);
        n = 1;
        chk({tag, " load_S"}, 32'(bus.S), 32'd3);
        chk({tag, " load_I"}, 32'(bus.I), 32'(d));
        chk({tag, " load_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, " ser_in"}, 32'(bus.ser_in), 32'(fl));
        tick();
        n++;
        shifts = 0;
        bad_mode = 0;
        while ((bus.S == 2'd1 || bus.S == 2'd2) && n < 60) begin
            if (bus.S !== exp_mode) bad_mode++;
            shifts++;
            tick();
            n++;
        end
        chk({tag, " shift_count"}, 32'(shifts), 32'(a));
        chk({tag, " shift_mode"}, 32'(bad_mode), 32'd0);
        chk({tag, " done"}, 32'(bus.done), 32'd1);
        chk({tag, " done_cycle"}, 32'(n), 32'(a + 2));
        tick();
        chk({tag, " ready_after"}, 32'(bus.ready), 32'd1);
        chk({tag, " done_clear"}, 32'(bus.done), 32'd0);
        chk({tag, " q"}, 32'(q), 32'(exp_q));
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        q = '0;
        rst = 1'b1;
        bus.start = 1'b0;
        drive(16'h0000, 1'b0, 5'd0, 1'b0);

        // reset held two cycles
        tick();
        tick();
        chk("rst_S", 32'(bus.S), 32'd0);
        chk("rst_I", 32'(bus.I), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_ser_in", 32'(bus.ser_in), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.ready), 32'd1);
        tick();

        run_op("left4", 16'h00F0, 1'b0, 5'd4, 1'b0, 4, 16'h0F00);
        run_op("right3", 16'h8001, 1'b1, 5'd3, 1'b1, 3, 16'hF000);
        run_op("amt0", 16'h1234, 1'b0, 5'd0, 1'b1, 0, 16'h1234);
        run_op("clamp31", 16'hFFFF, 1'b0, 5'd31, 1'b0, 16, 16'h0000);

        // start pulses while busy are ignored
        drive(16'h0003, 1'b0, 5'd2, 1'b1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 1;
        tick();
        n++;
        bus.start = 1'b1;
        tick();
        n++;
        bus.start = 1'b1;
        tick();
        n++;
        bus.start = 1'b0;
        chk("hs_done", 32'(bus.done), 32'd1);
        chk("hs_done_cycle", 32'(n), 32'd4);
        tick();
        chk("hs_ready", 32'(bus.ready), 32'd1);
        chk("hs_no_requeue_S", 32'(bus.S), 32'd0);
        tick();
        chk("hs_idle_busy", 32'(bus.busy), 32'd0);
        chk("hs_idle_done", 32'(bus.done), 32'd0);
        chk("hs_q", 32'(q), 32'h000F);

        // start held high: next request accepted in the first IDLE cycle after DONE
        drive(16'h0101, 1'b0, 5'd1, 1'b0);
        bus.start = 1'b1;
        tick();
        n = 1;
        chk("held_load1", 32'(bus.S), 32'd3);
        tick();
        n++;
        chk("held_shift1", 32'(bus.S), 32'd1);
        tick();
        n++;
        chk("held_done1", 32'(bus.done), 32'd1);
        tick();
        n++;
        chk("held_ready", 32'(bus.ready), 32'd1);
        drive(16'h0404, 1'b1, 5'd1, 1'b0);
        tick();
        n++;
        bus.start = 1'b0;
        chk("held_load2_cycle", 32'(n), 32'd5);
        chk("held_load2_S", 32'(bus.S), 32'd3);
        chk("held_load2_I", 32'(bus.I), 32'h0404);
        tick();
        chk("held_shift2", 32'(bus.S), 32'd2);
        tick();
        chk("held_done2", 32'(bus.done), 32'd1);
        tick();
        chk("held_q", 32'(q), 32'h0202);

        // reset during second shift cycle aborts without a done pulse
        drive(16'hABCD, 1'b0, 5'd8, 1'b1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("abort_shift1", 32'(bus.S), 32'd1);
        tick();
        chk("abort_shift2", 32'(bus.S), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_ready_in_rst", 32'(bus.ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("abort_S", 32'(bus.S), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_I", 32'(bus.I), 32'd0);
        chk("abort_ready", 32'(bus.ready), 32'd1);
        tick();
        chk("abort_no_done", 32'(bus.done), 32'd0);

        run_op("fresh", 16'h1111, 1'b1, 5'd1, 1'b0, 1, 16'h0888);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // hard cap so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
